// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 32-point FFT sequencing controller.
package fft_pkg;

  localparam int N_POINTS       = 32;
  localparam int N_STAGES       = 5;
  localparam int BFLY_PER_STAGE = 16;
  localparam int S_W            = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STAGE0 = 3'd1,
    STAGE1 = 3'd2,
    STAGE2 = 3'd3,
    STAGE3 = 3'd4,
    STAGE4 = 3'd5
  } state_t;

endpackage

// File: rtl/fft_bfly_counter.sv
// Butterfly/twiddle select counter: wraps modulo 16, flags the last butterfly of a stage.
module fft_bfly_counter
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [S_W-1:0] cnt,
  output logic           tc
);

  // Counter register: reset and clear take priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + S_W'(1);
    end
  end

  assign tc = (cnt == S_W'(BFLY_PER_STAGE - 1));

endmodule

// File: rtl/control_unit.sv
// Stage sequencer for the 32-point radix-2 FFT: walks STAGE0..STAGE4, 16 butterflies each.
module control_unit
  import fft_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  output logic           E0,
  output logic           E1,
  output logic           E2,
  output logic           E3,
  output logic           E4,
  output logic [S_W-1:0] S
);

  state_t         state;
  state_t         next_state;
  logic           cnt_clr;
  logic           cnt_en;
  logic           cnt_tc;
  logic [S_W-1:0] cnt;

  // The counter is held at zero while idle, so a frame always starts at S=0;
  // inside a stage it advances only when EN is high, which freezes S on a pause.
  assign cnt_clr = (state == IDLE);
  assign cnt_en  = EN;

  fft_bfly_counter u_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: advance a stage on the last butterfly, hold whenever EN is low.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (EN)           next_state = STAGE0;
      STAGE0:  if (EN && cnt_tc) next_state = STAGE1;
      STAGE1:  if (EN && cnt_tc) next_state = STAGE2;
      STAGE2:  if (EN && cnt_tc) next_state = STAGE3;
      STAGE3:  if (EN && cnt_tc) next_state = STAGE4;
      STAGE4:  if (EN && cnt_tc) next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // One-hot stage enables decoded straight from the state register.
  assign E0 = (state == STAGE0);
  assign E1 = (state == STAGE1);
  assign E2 = (state == STAGE2);
  assign E3 = (state == STAGE3);
  assign E4 = (state == STAGE4);
  assign S  = cnt;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: frame-position reference model, directed and random EN/RST.
module tb_control_unit;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       E0, E1, E2, E3, E4;
  logic [3:0] S;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Expected {E4,E3,E2,E1,E0,S} after each driven edge.
  logic [8:0] exp_q[$];

  // Reference model: position within a frame. 0 = idle, 1..80 = enabled cycle index.
  int pos = 0;

  control_unit dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .E0  (E0),
    .E1  (E1),
    .E2  (E2),
    .E3  (E3),
    .E4  (E4),
    .S   (S)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [8:0] expected_of(input int p);
    logic [4:0] e;
    logic [3:0] s;
    e = '0;
    s = '0;
    if (p != 0) begin
      e[(p - 1) / 16] = 1'b1;
      s = 4'((p - 1) % 16);
    end
    return {e, s};
  endfunction

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic step(input logic rst, input logic en);
    @(negedge CLK);
    RST = rst;
    EN  = en;
    if (rst)           pos = 0;
    else if (pos == 0) pos = en ? 1 : 0;
    else if (en)       pos = (pos == 80) ? 0 : pos + 1;
    exp_q.push_back(expected_of(pos));
  endtask

  // Monitor: compare DUT outputs just after each rising edge.
  always @(posedge CLK) begin
    logic [8:0] exp_v;
    logic [8:0] act_v;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {E4, E3, E2, E1, E0, S};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got E4..E0=%b S=%0d, expected E4..E0=%b S=%0d",
                 cycle, act_v[8:4], act_v[3:0], exp_v[8:4], exp_v[3:0]);
      end
      checks++;
      if ($countones(act_v[8:4]) > 1) begin
        errors++;
        $display("FAIL onehot cycle %0d: got E4..E0=%b, required at most one high",
                 cycle, act_v[8:4]);
      end
    end
  end

  initial begin
    int guard;
    RST = 1'b1;
    EN  = 1'b0;

    // Reset held, then idle with EN low.
    repeat (4) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);

    // One full frame, then back to idle.
    repeat (80) step(1'b0, 1'b1);
    repeat (3)  step(1'b0, 1'b0);

    // Back-to-back frames with EN held high.
    repeat (200) step(1'b0, 1'b1);
    step(1'b1, 1'b0);

    // Pause at STAGE2, S=7 for three cycles, then resume.
    guard = 0;
    while (pos != 40 && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    repeat (3)  step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1);
    step(1'b1, 1'b0);

    // Mid-frame reset at STAGE3, S=10 with EN high.
    guard = 0;
    while (pos != 59 && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);

    // Reset has priority over EN.
    repeat (3) step(1'b1, 1'b1);

    // Randomized EN with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0);
    end

    // Drain the scoreboard, bounded.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
